// File: rtl/mul_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// mul_unit : iterative radix-2 shift-add multiplier (MUL/UMULL/SMULL)
// Revision : 1.0
// ------------------------------------------------------------------
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       MulFlags
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [5:0]         count;
  logic               sign;
  logic               long_op;
  logic               is_long_in;
  logic               is_smull_in;
  logic [1:0]         flags_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (Start) state_next = RUN;
      RUN: begin
        Busy = 1'b1;
        if (count == LAST_STEP) state_next = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // SMULL multiplies magnitudes and fixes the sign at the end; 0x80000000 stays 2^31 unsigned.
  always_comb begin
    is_smull_in = (MulOp == 2'b10);
    is_long_in  = (MulOp == 2'b01) || is_smull_in;
    mag_a       = (is_smull_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b       = (is_smull_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    acc_step    = mplier[0] ? (acc + mcand) : acc;
    product     = sign ? -acc_step : acc_step;
    if (long_op) flags_next = {product[2*WIDTH-1], product == '0};
    else         flags_next = {product[WIDTH-1], product[WIDTH-1:0] == '0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      sign     <= 1'b0;
      long_op  <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            acc     <= '0;
            count   <= '0;
            sign    <= is_smull_in & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            long_op <= is_long_in;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
          // Final step: commit the signed result straight from the last partial sum.
          if (count == LAST_STEP) begin
            ResultLo <= product[WIDTH-1:0];
            ResultHi <= long_op ? product[2*WIDTH-1:WIDTH] : '0;
            MulFlags <= flags_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// Self-checking bench for mul_unit: scoreboard of expected products against Done.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MulOp = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] ResultLo, ResultHi;
  logic        Busy, Done;
  logic [1:0]  MulFlags;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  flags;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MulOp(MulOp),
    .SrcA(SrcA), .SrcB(SrcB), .ResultLo(ResultLo), .ResultHi(ResultHi),
    .Busy(Busy), .Done(Done), .MulFlags(MulFlags)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    case (op)
      2'b01:   p = {32'd0, a} * {32'd0, b};
      2'b10:   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      default: p = {32'd0, a * b};
    endcase
    e.lo = p[31:0];
    e.hi = p[63:32];
    if (op == 2'b01 || op == 2'b10) e.flags = {p[63], p == 64'd0};
    else                            e.flags = {p[31], p[31:0] == 32'd0};
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MulOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    sb.push_back(model(op, a, b));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      Start = 1'b0;
    end while (!Done && lat < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b1; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got Busy=%b Done=%b want 0 0", Busy, Done);
    end
    n_checks++;
    if (ResultLo !== 32'd0 || ResultHi !== 32'd0 || MulFlags !== 2'b00) begin
      n_fail++; $display("FAIL reset_outputs got %h_%h flags=%b want zero", ResultHi, ResultLo, MulFlags);
    end
    reset = 1'b0; Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] ta [4] = '{32'd3, 32'd0, 32'd7, 32'hFFFF_0001};
    logic [31:0] tb [4] = '{32'd5, 32'h1234, 32'd6, 32'h0001_0003};
    logic [1:0]  to [4] = '{2'b00, 2'b00, 2'b11, 2'b00};
    exp_t e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat); end
      n_checks++;
      if (ResultLo !== e.lo || ResultHi !== e.hi) begin
        n_fail++; $display("FAIL mul_result[%0d] got %h_%h want %h_%h", i, ResultHi, ResultLo, e.hi, e.lo);
      end
      n_checks++;
      if (MulFlags !== e.flags) begin n_fail++; $display("FAIL mul_flags[%0d] got %b want %b", i, MulFlags, e.flags); end
      @(negedge clk);
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || ResultLo !== e.lo || MulFlags !== e.flags) begin
        n_fail++; $display("FAIL mul_hold[%0d] got Done=%b Busy=%b lo=%h flags=%b want 0 0 %h %b",
                           i, Done, Busy, ResultLo, MulFlags, e.lo, e.flags);
      end
    end
  endtask

  task automatic test_long();
    logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
    logic [31:0] tb [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic [1:0]  to [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    exp_t e;
    int lat;
    tb[5] = $urandom;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) issue(to[i], ta[i], tb[i]);
      else       issue(2'b01 + 2'(i - 6), $urandom, $urandom);
      wait_done(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 33) begin n_fail++; $display("FAIL long_latency[%0d] got %0d want 33", i, lat); end
      n_checks++;
      if (ResultLo !== e.lo || ResultHi !== e.hi) begin
        n_fail++; $display("FAIL long_result[%0d] got %h_%h want %h_%h", i, ResultHi, ResultLo, e.hi, e.lo);
      end
      n_checks++;
      if (MulFlags !== e.flags) begin n_fail++; $display("FAIL long_flags[%0d] got %b want %b", i, MulFlags, e.flags); end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int lat = 0;
    int done_cnt = 0;
    logic [31:0] lo_c = '0, hi_c = '0;
    logic [1:0]  fl_c = '0;
    logic        busy34 = 1'b1;
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (Done) begin
        done_cnt++;
        if (done_cnt == 1) begin lat = c; lo_c = ResultLo; hi_c = ResultHi; fl_c = MulFlags; end
      end
      if (c == 34) busy34 = Busy;
      if (c == 5 || c == 33) begin
        Start = 1'b1; MulOp = 2'b10; SrcA = $urandom | 32'h8000_0000; SrcB = $urandom | 32'h1;
      end else begin
        Start = 1'b0;
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (done_cnt !== 1 || lat !== 33) begin
      n_fail++; $display("FAIL ignore_done got count=%0d at=%0d want 1 at 33", done_cnt, lat);
    end
    n_checks++;
    if (lo_c !== e.lo || hi_c !== e.hi || fl_c !== e.flags) begin
      n_fail++; $display("FAIL ignore_result got %h_%h/%b want %h_%h/%b", hi_c, lo_c, fl_c, e.hi, e.lo, e.flags);
    end
    n_checks++;
    if (busy34 !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after got %b want 0", busy34); end
    n_checks++;
    if (ResultLo !== e.lo || ResultHi !== e.hi) begin
      n_fail++; $display("FAIL ignore_hold got %h_%h want %h_%h", ResultHi, ResultLo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int lat;
    int done_cnt = 0;
    issue(2'b01, 32'hDEAD_BEEF, 32'h0123_4567);
    sb.pop_back();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl got Busy=%b Done=%b want 0 0", Busy, Done);
    end
    n_checks++;
    if (ResultLo !== 32'd0 || ResultHi !== 32'd0 || MulFlags !== 2'b00) begin
      n_fail++; $display("FAIL abort_outputs got %h_%h/%b want zero", ResultHi, ResultLo, MulFlags);
    end
    repeat (40) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt); end
    issue(2'b01, 32'd2, 32'd3);
    wait_done(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 33 || ResultLo !== e.lo || ResultHi !== e.hi || MulFlags !== e.flags) begin
      n_fail++; $display("FAIL abort_restart got lat=%0d %h_%h/%b want 33 %h_%h/%b",
                         lat, ResultHi, ResultLo, MulFlags, e.hi, e.lo, e.flags);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(2'(i), $urandom, $urandom);
      wait_done(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 33 || ResultLo !== e.lo || ResultHi !== e.hi || MulFlags !== e.flags) begin
        n_fail++; $display("FAIL b2b[%0d] got lat=%0d %h_%h/%b want 33 %h_%h/%b",
                           i, lat, ResultHi, ResultLo, MulFlags, e.hi, e.lo, e.flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_long();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
